// File: rtl/ctrl_pkg.sv
// Shared types for the control sequencer: opcodes, FSM states,
// RAM address select codes and the decoded-op bundle.
package ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_MOVA = 4'h1,
        OP_MOVB = 4'h2,
        OP_MOVC = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_AND  = 4'h6,
        OP_NOT  = 4'h7,
        OP_RSR  = 4'h8,
        OP_RSL  = 4'h9,
        OP_JMP  = 4'hA,
        OP_JZ   = 4'hB,
        OP_JC   = 4'hC,
        OP_IN   = 4'hD,
        OP_OUT  = 4'hE,
        OP_HALT = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_PAUSE,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        CLS_SINGLE,
        CLS_MEM,
        CLS_IO,
        CLS_HALT
    } cls_e;

    typedef enum logic [1:0] {
        CND_NONE,
        CND_Z,
        CND_C
    } cnd_e;

    localparam logic [1:0] MADD_PC = 2'b00;
    localparam logic [1:0] MADD_LD = 2'b01;
    localparam logic [1:0] MADD_ST = 2'b10;

    typedef struct packed {
        cls_e       cls;
        cnd_e       cnd;
        logic [1:0] madd;
        logic       rd;
        logic       wr;
        logic       io_in;
        logic       alu_m;
        logic       fbus;
        logic       flbus;
        logic       frbus;
        logic       cf_en;
        logic       zf_en;
        logic       reg_we;
    } dec_t;

endpackage

// File: rtl/ctrl_seq_if.sv
// RAM and I/O port handshake bundle between sequencer and datapath.
interface ctrl_seq_if;

    logic       mem_ready;
    logic       in_valid;
    logic       out_ready;
    logic [1:0] madd;
    logic       ram_dl;
    logic       ram_xl;
    logic       in_en;
    logic       out_en;

    modport master (
        input  mem_ready, in_valid, out_ready,
        output madd, ram_dl, ram_xl, in_en, out_en
    );

    modport slave (
        output mem_ready, in_valid, out_ready,
        input  madd, ram_dl, ram_xl, in_en, out_en
    );

endinterface

// File: rtl/ctrl_decode.sv
// Opcode to op-class and ALU/shifter/flag control decode.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] op,
    output dec_t            dec
);

    always_comb begin
        dec = '0;
        unique case (op)
            OP_W'(OP_MOVA): begin
                dec.fbus   = 1'b1;
                dec.reg_we = 1'b1;
            end
            OP_W'(OP_MOVB): begin
                dec.cls  = CLS_MEM;
                dec.madd = MADD_ST;
                dec.wr   = 1'b1;
            end
            OP_W'(OP_MOVC): begin
                dec.cls  = CLS_MEM;
                dec.madd = MADD_LD;
                dec.rd   = 1'b1;
            end
            OP_W'(OP_ADD), OP_W'(OP_SUB): begin
                dec.fbus   = 1'b1;
                dec.alu_m  = 1'b1;
                dec.cf_en  = 1'b1;
                dec.zf_en  = 1'b1;
                dec.reg_we = 1'b1;
            end
            OP_W'(OP_AND), OP_W'(OP_NOT): begin
                dec.fbus   = 1'b1;
                dec.alu_m  = 1'b1;
                dec.reg_we = 1'b1;
            end
            OP_W'(OP_RSR): begin
                dec.frbus  = 1'b1;
                dec.cf_en  = 1'b1;
                dec.reg_we = 1'b1;
            end
            OP_W'(OP_RSL): begin
                dec.flbus  = 1'b1;
                dec.cf_en  = 1'b1;
                dec.reg_we = 1'b1;
            end
            OP_W'(OP_JMP), OP_W'(OP_JZ), OP_W'(OP_JC): begin
                dec.cls  = CLS_MEM;
                dec.madd = MADD_PC;
                dec.rd   = 1'b1;
                if (op == OP_W'(OP_JZ)) dec.cnd = CND_Z;
                if (op == OP_W'(OP_JC)) dec.cnd = CND_C;
            end
            OP_W'(OP_IN): begin
                dec.cls   = CLS_IO;
                dec.io_in = 1'b1;
            end
            OP_W'(OP_OUT): begin
                dec.cls  = CLS_IO;
                dec.fbus = 1'b1;
            end
            OP_W'(OP_HALT): dec.cls = CLS_HALT;
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle fetch/execute sequencer with memory/I/O wait states,
// single-step pause, halt/restart and a retired-instruction counter.
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int IR_W  = 8,
    parameter int OP_W  = 4,
    parameter int RA_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IR_W-1:0]  ir,
    input  logic             z,
    input  logic             c,
    input  logic             start,
    input  logic             single_step,
    ctrl_seq_if.master       bus,
    output logic [RA_W-1:0]  reg_ra,
    output logic [RA_W-1:0]  reg_wa,
    output logic [OP_W-1:0]  alu_s,
    output logic             alu_m,
    output logic             shi_fbus,
    output logic             shi_flbus,
    output logic             shi_frbus,
    output logic             cf_en,
    output logic             zf_en,
    output logic             pc_ld,
    output logic             pc_inc,
    output logic             ir_ld,
    output logic             reg_we,
    output logic             halted,
    output logic             paused,
    output logic [CNT_W-1:0] instr_cnt
);

    if (IR_W < OP_W + 2 * RA_W) begin : g_bad_ir_w
        $error("ctrl_seq: IR_W must be >= OP_W + 2*RA_W");
    end

    state_e state, nxt;
    dec_t   dec;
    logic   taken;
    logic   retire;

    assign alu_s  = ir[IR_W-1 -: OP_W];
    assign reg_ra = ir[RA_W-1:0];
    assign reg_wa = ir[2*RA_W-1:RA_W];

    ctrl_decode #(.OP_W(OP_W)) u_dec (
        .op  (alu_s),
        .dec (dec)
    );

    assign taken = (dec.cnd == CND_NONE)
                 | ((dec.cnd == CND_Z) & z)
                 | ((dec.cnd == CND_C) & c);

    assign halted = (state == ST_HALT) & ~rst;
    assign paused = (state == ST_PAUSE) & ~rst;

    always_comb begin
        nxt        = state;
        retire     = 1'b0;
        bus.madd   = MADD_PC;
        bus.ram_dl = 1'b0;
        bus.ram_xl = 1'b0;
        bus.in_en  = 1'b0;
        bus.out_en = 1'b0;
        alu_m      = 1'b0;
        shi_fbus   = 1'b0;
        shi_flbus  = 1'b0;
        shi_frbus  = 1'b0;
        cf_en      = 1'b0;
        zf_en      = 1'b0;
        pc_ld      = 1'b0;
        pc_inc     = 1'b0;
        ir_ld      = 1'b0;
        reg_we     = 1'b0;
        // reset forces FETCH-shaped outputs and drops any pending commit
        if (rst) begin
            bus.ram_dl = 1'b1;
            nxt        = ST_FETCH;
        end else begin
            unique case (state)
                ST_FETCH: begin
                    bus.ram_dl = 1'b1;
                    if (bus.mem_ready) begin
                        ir_ld  = 1'b1;
                        pc_inc = 1'b1;
                        nxt    = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    alu_m     = dec.alu_m;
                    shi_fbus  = dec.fbus;
                    shi_flbus = dec.flbus;
                    shi_frbus = dec.frbus;
                    cf_en     = dec.cf_en;
                    zf_en     = dec.zf_en;
                    unique case (dec.cls)
                        CLS_SINGLE: begin
                            reg_we = dec.reg_we;
                            retire = 1'b1;
                        end
                        CLS_MEM: begin
                            if (!taken) begin
                                pc_inc = 1'b1;
                                retire = 1'b1;
                            end else begin
                                bus.madd   = dec.madd;
                                bus.ram_dl = dec.rd;
                                bus.ram_xl = dec.wr;
                                reg_we = bus.mem_ready & (dec.madd == MADD_LD);
                                pc_ld  = bus.mem_ready & (dec.madd == MADD_PC) & dec.rd;
                                retire = bus.mem_ready;
                            end
                        end
                        CLS_IO: begin
                            if (dec.io_in) begin
                                bus.in_en = 1'b1;
                                reg_we    = bus.in_valid;
                                retire    = bus.in_valid;
                            end else begin
                                bus.out_en = 1'b1;
                                retire     = bus.out_ready;
                            end
                        end
                        CLS_HALT: nxt = ST_HALT;
                    endcase
                    if (retire) nxt = single_step ? ST_PAUSE : ST_FETCH;
                end
                ST_PAUSE, ST_HALT: begin
                    if (start) nxt = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            instr_cnt <= '0;
        end else begin
            state <= nxt;
            if (retire) instr_cnt <= instr_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed-vector bench for ctrl_seq, counter width 4 to reach wrap.
module tb_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ir;
    logic       z, c, start, single_step;
    logic [1:0] reg_ra, reg_wa;
    logic [3:0] alu_s;
    logic       alu_m, shi_fbus, shi_flbus, shi_frbus, cf_en, zf_en;
    logic       pc_ld, pc_inc, ir_ld, reg_we, halted, paused;
    logic [3:0] instr_cnt;
    int         n_run = 0;
    int         n_fail = 0;

    ctrl_seq_if bus ();

    always #5 clk = ~clk;

    ctrl_seq #(.IR_W(8), .OP_W(4), .RA_W(2), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .ir          (ir),
        .z           (z),
        .c           (c),
        .start       (start),
        .single_step (single_step),
        .bus         (bus),
        .reg_ra      (reg_ra),
        .reg_wa      (reg_wa),
        .alu_s       (alu_s),
        .alu_m       (alu_m),
        .shi_fbus    (shi_fbus),
        .shi_flbus   (shi_flbus),
        .shi_frbus   (shi_frbus),
        .cf_en       (cf_en),
        .zf_en       (zf_en),
        .pc_ld       (pc_ld),
        .pc_inc      (pc_inc),
        .ir_ld       (ir_ld),
        .reg_we      (reg_we),
        .halted      (halted),
        .paused      (paused),
        .instr_cnt   (instr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; ir = 8'h00; z = 1'b0; c = 1'b0;
        start = 1'b0; single_step = 1'b0;
        bus.mem_ready = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;

        cyc(); #1;
        chk("rst_ram_dl", 32'(bus.ram_dl), 1);
        chk("rst_madd", 32'(bus.madd), 0);
        chk("rst_ir_ld", 32'(ir_ld), 0);
        chk("rst_pc_inc", 32'(pc_inc), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_paused", 32'(paused), 0);
        chk("rst_cnt", 32'(instr_cnt), 0);
        chk("rst_reg_we", 32'(reg_we), 0);

        cyc(); rst = 1'b0; ir = 8'h00; #1;
        chk("nop_ir_ld", 32'(ir_ld), 1);
        chk("nop_pc_inc", 32'(pc_inc), 1);
        cyc(); #1;
        chk("nop_reg_we", 32'(reg_we), 0);
        chk("nop_ram_dl", 32'(bus.ram_dl), 0);
        cyc(); ir = 8'h46; #1;
        chk("add_f_cnt", 32'(instr_cnt), 1);
        cyc(); #1;
        chk("add_reg_we", 32'(reg_we), 1);
        chk("add_alu_m", 32'(alu_m), 1);
        chk("add_cf_en", 32'(cf_en), 1);
        chk("add_zf_en", 32'(zf_en), 1);
        chk("add_fbus", 32'(shi_fbus), 1);
        chk("add_wa", 32'(reg_wa), 1);
        chk("add_ra", 32'(reg_ra), 2);
        chk("add_alu_s", 32'(alu_s), 4);
        cyc(); ir = 8'h90; #1;
        cyc(); #1;
        chk("rsl_flbus", 32'(shi_flbus), 1);
        chk("rsl_cf_en", 32'(cf_en), 1);
        chk("rsl_zf_en", 32'(zf_en), 0);
        chk("rsl_alu_m", 32'(alu_m), 0);
        chk("rsl_reg_we", 32'(reg_we), 1);

        cyc(); ir = 8'h30; #1;
        chk("movc_f_cnt", 32'(instr_cnt), 3);
        for (int i = 0; i < 4; i++) begin
            cyc(); bus.mem_ready = (i == 3); #1;
            chk("movc_madd", 32'(bus.madd), 1);
            chk("movc_ram_dl", 32'(bus.ram_dl), 1);
            chk("movc_reg_we", 32'(reg_we), (i == 3) ? 1 : 0);
        end

        cyc(); bus.mem_ready = 1'b1; ir = 8'hB0; z = 1'b0; #1;
        chk("jz0_f_cnt", 32'(instr_cnt), 4);
        cyc(); #1;
        chk("jz0_pc_inc", 32'(pc_inc), 1);
        chk("jz0_pc_ld", 32'(pc_ld), 0);
        chk("jz0_ram_dl", 32'(bus.ram_dl), 0);
        cyc(); z = 1'b1; #1;
        chk("jz1_f_cnt", 32'(instr_cnt), 5);
        cyc(); #1;
        chk("jz1_pc_ld", 32'(pc_ld), 1);
        chk("jz1_madd", 32'(bus.madd), 0);
        chk("jz1_ram_dl", 32'(bus.ram_dl), 1);
        chk("jz1_pc_inc", 32'(pc_inc), 0);

        cyc(); ir = 8'hD0; z = 1'b0; #1;
        chk("in_f_cnt", 32'(instr_cnt), 6);
        for (int i = 0; i < 3; i++) begin
            cyc(); bus.in_valid = (i == 2); #1;
            chk("in_en", 32'(bus.in_en), 1);
            chk("in_reg_we", 32'(reg_we), (i == 2) ? 1 : 0);
            chk("in_cnt", 32'(instr_cnt), 6);
        end

        cyc(); bus.in_valid = 1'b0; ir = 8'hE0; bus.out_ready = 1'b0; #1;
        chk("out_f_cnt", 32'(instr_cnt), 7);
        for (int i = 0; i < 4; i++) begin
            cyc(); bus.out_ready = (i == 3); #1;
            chk("out_en", 32'(bus.out_en), 1);
            chk("out_fbus", 32'(shi_fbus), 1);
            chk("out_cnt", 32'(instr_cnt), 7);
        end

        cyc(); ir = 8'hF0; #1;
        chk("hlt_f_cnt", 32'(instr_cnt), 8);
        cyc(); #1;
        chk("hlt_x_ir_ld", 32'(ir_ld), 0);
        chk("hlt_x_ram_dl", 32'(bus.ram_dl), 0);
        cyc(); #1;
        chk("hlt_halted", 32'(halted), 1);
        chk("hlt_ram_dl", 32'(bus.ram_dl), 0);
        chk("hlt_pc_inc", 32'(pc_inc), 0);
        chk("hlt_cnt", 32'(instr_cnt), 8);
        cyc(); start = 1'b1; #1;
        chk("hlt_start_halted", 32'(halted), 1);
        cyc(); start = 1'b0; ir = 8'h00; single_step = 1'b1; #1;
        chk("rst_from_hlt_halted", 32'(halted), 0);
        chk("rst_from_hlt_ram_dl", 32'(bus.ram_dl), 1);

        cyc(); start = 1'b1; #1;
        cyc(); start = 1'b0; #1;
        chk("ss_paused", 32'(paused), 1);
        chk("ss_cnt", 32'(instr_cnt), 9);
        chk("ss_ram_dl", 32'(bus.ram_dl), 0);
        cyc(); start = 1'b1; single_step = 1'b0; #1;
        chk("ss_start_paused", 32'(paused), 1);
        cyc(); start = 1'b0; ir = 8'h20; #1;
        chk("ss_resume_paused", 32'(paused), 0);
        chk("ss_resume_ram_dl", 32'(bus.ram_dl), 1);

        cyc(); bus.mem_ready = 1'b0; #1;
        chk("movb_ram_xl", 32'(bus.ram_xl), 1);
        chk("movb_madd", 32'(bus.madd), 2);
        cyc(); rst = 1'b1; bus.mem_ready = 1'b1; #1;
        chk("movb_rst_ram_xl", 32'(bus.ram_xl), 0);
        chk("movb_rst_madd", 32'(bus.madd), 0);
        chk("movb_rst_ram_dl", 32'(bus.ram_dl), 1);
        chk("movb_rst_ir_ld", 32'(ir_ld), 0);
        chk("movb_rst_pc_inc", 32'(pc_inc), 0);
        cyc(); rst = 1'b0; bus.mem_ready = 1'b0; #1;
        chk("post_rst_ram_dl", 32'(bus.ram_dl), 1);
        chk("post_rst_ram_xl", 32'(bus.ram_xl), 0);
        chk("post_rst_cnt", 32'(instr_cnt), 0);

        bus.mem_ready = 1'b1; ir = 8'h00;
        for (int k = 0; k < 15; k++) begin
            cyc();
            cyc();
        end
        #1;
        chk("wrap_cnt15", 32'(instr_cnt), 15);
        cyc();
        cyc(); #1;
        chk("wrap_cnt0", 32'(instr_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Parametrised multi-cycle control sequencer for the model CPU, replacing the purely combinational control decoder plus external `sm` toggle. It owns the fetch/execute state machine, decodes the instruction register, and drives register-file, ALU, shifter, PC, RAM-address-mux and I/O control lines. It adds wait-state handshakes for memory and I/O, single-step pause/resume, halt/restart, and a retired-instruction counter.

## Interface
Parameters:
- `IR_W`, 8, instruction register width
- `OP_W`, 4, opcode width, taken from `ir[IR_W-1 -: OP_W]`
- `RA_W`, 2, register address width; `IR_W >= OP_W + 2*RA_W` is required (elaboration error otherwise)
- `CNT_W`, 16, retired-instruction counter width

Ports:
- `clk` in 1: sole clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `ir` in IR_W: current instruction, from the external IR register
- `z`, `c` in 1: flag register outputs
- `mem_ready` in 1: RAM access completes this cycle
- `in_valid` in 1: input port has data
- `out_ready` in 1: output port accepts data
- `start` in 1: resume from HALT or PAUSE
- `single_step` in 1: pause after every retired instruction
- `reg_ra` out RA_W: `ir[RA_W-1:0]`
- `reg_wa` out RA_W: `ir[2*RA_W-1:RA_W]`
- `madd` out 2: RAM address select; 00 = PC, 01 = load address (reg), 10 = store address (reg)
- `alu_s` out OP_W: opcode passthrough
- `alu_m`, `shi_fbus`, `shi_flbus`, `shi_frbus`, `cf_en`, `zf_en` out 1: ALU/shifter/flag controls
- `pc_ld`, `pc_inc`, `ir_ld`, `ram_dl`, `ram_xl`, `reg_we`, `in_en`, `out_en` out 1: all active-high (`reg_we` active-high is a deliberate change)
- `halted`, `paused` out 1: state indicators
- `instr_cnt` out CNT_W: retired instructions, wraps

## Operation
- Opcodes (package): 0 NOP, 1 MOVA, 2 MOVB (store), 3 MOVC (load), 4 ADD, 5 SUB, 6 AND, 7 NOT, 8 RSR, 9 RSL, A JMP, B JZ, C JC, D IN, E OUT, F HALT.
- States: FETCH, EXEC, PAUSE, HALT. Reset → FETCH.
- FETCH: `madd`=00, `ram_dl`=1. While `mem_ready`=0, stay. When `mem_ready`=1: `ir_ld`=1, `pc_inc`=1, → EXEC.
- EXEC, single-cycle ops (NOP, MOVA, ADD–RSL, JZ not taken, JC not taken): retire this cycle.
  - MOVA, ADD–NOT, OUT: `shi_fbus`=1. RSL: `shi_flbus`=1. RSR: `shi_frbus`=1.
  - ADD–NOT: `alu_m`=1. ADD/SUB/RSR/RSL: `cf_en`=1. ADD/SUB: `zf_en`=1.
  - MOVA and ADD–RSL: `reg_we`=1.
  - JZ with z=0, or JC with c=0: `pc_inc`=1 to skip the operand word.
- EXEC, memory ops: strobes are held until `mem_ready`. Commit signals are qualified by `mem_ready`. Retire on `mem_ready`.
  - MOVB: `madd`=10, `ram_xl`=1.
  - MOVC: `madd`=01, `ram_dl`=1, `reg_we`=`mem_ready`.
  - JMP, JZ with z=1, JC with c=1: `madd`=00, `ram_dl`=1, `pc_ld`=`mem_ready`.
- EXEC, IN: `in_en`=1. `reg_we`=`in_valid`. Retire on `in_valid`.
- EXEC, OUT: `out_en`=1. Retire on `out_ready`.
- EXEC, HALT: → HALT. Not counted as retired.
- On retire: `instr_cnt`++ (modulo 2^CNT_W). Next state is PAUSE if `single_step`=1, else FETCH.
- PAUSE and HALT: all strobes are 0. `paused`/`halted` is 1. When `start`=1 → FETCH next cycle.
- While in FETCH/EXEC, `start` is ignored.
- In every state, any control line not listed above is 0.

## Timing
- State and `instr_cnt` are registered. Control outputs are combinational from state, `ir`, `z`, `c` and the handshake inputs.
- Zero-wait instruction: 2 cycles (FETCH + EXEC). Each wait cycle adds 1.
- `z`/`c` are sampled combinationally in EXEC. A flag update from the previous instruction is therefore visible.
- Reset values: state FETCH, `instr_cnt`=0, `halted`=`paused`=0.
  - During and after reset, outputs follow FETCH: `madd`=00, `ram_dl`=1. `ir_ld`/`pc_inc` are 0 while `rst`=1, regardless of `mem_ready`.
  - All other strobes are 0.
- `rst` mid-wait aborts the access without a commit. Next cycle is FETCH.
- `start` and `single_step` asserted in the same retire cycle: go to PAUSE. `start` is honoured only from the following cycle.

## Structure
- Package `ctrl_pkg`: opcode enum (`OP_NOP`…`OP_HALT`), state enum, `madd` constants (`MADD_PC`, `MADD_LD`, `MADD_ST`).
- Sub-module `ctrl_decode`: purely combinational opcode → op-class (single / mem / io / halt) and ALU/shifter controls. `ctrl_seq` holds the FSM, handshake qualification and counter.

## Test plan
- Zero-wait NOP, ADD (`ir`=0x46), RSL sequence with `mem_ready`=1 → 2 cycles each; ADD EXEC has `reg_we`=`alu_m`=`cf_en`=`zf_en`=1, `reg_wa`=01, `reg_ra`=10; `instr_cnt` reaches 3.
- MOVC with `mem_ready` low 3 cycles → `madd`=01 and `ram_dl`=1 held 4 cycles, `reg_we` high only on the last.
- JZ with z=0 → `pc_inc`=1, `pc_ld`=0. JZ with z=1 → `pc_ld`=1, `madd`=00.
- IN with `in_valid` after 2 cycles; OUT with `out_ready`=0 held → state stays EXEC, no counter increment until the handshake.
- HALT → `halted`=1, strobes 0, counter unchanged; `start` pulse → FETCH. `single_step`=1 → PAUSE after every instruction.
- `rst` during a MOVB wait → no `ram_xl` commit, FETCH next cycle, `instr_cnt`=0. Counter with CNT_W=4 wraps from 15 to 0.
